// File: rtl/tdm_demux4_pkg.sv
// Shared constants and types for the four-lane TDM demultiplexer.
package tdm_pkg;

   localparam int LANES = 4;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx);
      lane_onehot      = '0;
      lane_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Sample stream in, per-lane and per-frame results out, for tdm_demux4.
interface tdm_demux4_if
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8
);

   // in_valid qualifies in_data and in_sof for one cycle; there is no
   // backpressure, so every beat with in_valid=1 is consumed on that edge.
   logic                         in_valid;
   logic [WIDTH-1:0]             in_data;
   logic                         in_sof;
   lane_idx_t                    sel;
   logic [LANES-1:0][WIDTH-1:0]  lane_data;
   logic [LANES-1:0]             lane_valid;
   logic [LANES-1:0][WIDTH-1:0]  frame_data;
   logic                         frame_valid;
   logic                         sof_err;

   modport master (
      output in_valid, in_data, in_sof,
      input  sel, lane_data, lane_valid, frame_data, frame_valid, sof_err
   );

   modport slave (
      input  in_valid, in_data, in_sof,
      output sel, lane_data, lane_valid, frame_data, frame_valid, sof_err
   );

endinterface

// File: rtl/tdm_demux4.sv
// Demultiplexes a 4-lane TDM sample stream into per-lane registers and
// publishes a coherent snapshot each time a complete frame has been seen.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   tdm_demux4_if.slave     bus,
   output state_t          dbg_state
);

   state_t                       state_q, state_d;
   lane_idx_t                    sel_q, sel_d;
   logic                         frame_ok_q, frame_ok_d;
   logic [LANES-1:0]             lane_we;
   logic                         load_frame;
   logic                         sof_err_d;
   logic [LANES-1:0][WIDTH-1:0]  lane_q;
   logic [LANES-1:0][WIDTH-1:0]  frame_q;
   logic [LANES-1:0]             lane_valid_q;
   logic                         frame_valid_q;
   logic                         sof_err_q;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      frame_ok_d = frame_ok_q;
      lane_we    = '0;
      load_frame = 1'b0;
      sof_err_d  = 1'b0;
      case (state_q)
         HUNT: begin
            if (bus.in_valid && bus.in_sof) begin
               lane_we    = lane_onehot(2'd0);
               sel_d      = 2'd1;
               frame_ok_d = 1'b1;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            if (bus.in_valid) begin
               if (bus.in_sof && (sel_q != 2'd0)) begin
                  // Resync: the partial frame is abandoned, this beat starts a new one.
                  sof_err_d  = 1'b1;
                  lane_we    = lane_onehot(2'd0);
                  sel_d      = 2'd1;
                  frame_ok_d = 1'b1;
               end else begin
                  lane_we = lane_onehot(sel_q);
                  sel_d   = sel_q + 2'd1;
                  if (sel_q == 2'd0) frame_ok_d = 1'b1;
                  if (sel_q == 2'd3) begin
                     load_frame = frame_ok_q;
                     frame_ok_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         sel_q         <= '0;
         frame_ok_q    <= 1'b0;
         lane_q        <= '0;
         frame_q       <= '0;
         lane_valid_q  <= '0;
         frame_valid_q <= 1'b0;
         sof_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         frame_ok_q    <= frame_ok_d;
         lane_valid_q  <= lane_we;
         frame_valid_q <= load_frame;
         sof_err_q     <= sof_err_d;
         for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) lane_q[k] <= bus.in_data;
         end
         // Lane 3 arrives on this same edge, so take it straight from the input.
         if (load_frame) frame_q <= {bus.in_data, lane_q[2], lane_q[1], lane_q[0]};
      end
   end

   assign bus.sel         = sel_q;
   assign bus.lane_data   = lane_q;
   assign bus.lane_valid  = lane_valid_q;
   assign bus.frame_data  = frame_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.sof_err     = sof_err_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
module tb_tdm_demux4;
   import tdm_pkg::*;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;
   int     pass_cnt;
   int     total_cnt;
   logic [31:0] exp_q[$];

   tdm_demux4_if #(.WIDTH(8)) bus ();

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drivers: every task starts and ends 1 time unit after a rising edge.
   task automatic beat(input logic [7:0] d, input logic s);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sof   = s;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = 8'h00;
      #3;
      total_cnt++; if (bus.sel !== 2'd0) $display("FAIL reset_sel: got %0d exp 0", bus.sel); else pass_cnt++;
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL reset_lane_valid: got %b exp 0000", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL reset_frame_valid: got %b exp 0", bus.frame_valid); else pass_cnt++;
      total_cnt++; if (bus.sof_err !== 1'b0) $display("FAIL reset_sof_err: got %b exp 0", bus.sof_err); else pass_cnt++;
      total_cnt++; if (bus.lane_data !== 32'h0) $display("FAIL reset_lane_data: got %h exp 0", bus.lane_data); else pass_cnt++;
      total_cnt++; if (bus.frame_data !== 32'h0) $display("FAIL reset_frame_data: got %h exp 0", bus.frame_data); else pass_cnt++;
      total_cnt++; if (dbg_state !== HUNT) $display("FAIL reset_state: got %0d exp HUNT", dbg_state); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_aligned();
      beat(8'h11, 1'b1);
      total_cnt++; if (bus.lane_valid !== 4'b0001) $display("FAIL aligned_lv0: got %b exp 0001", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.lane_data[0] !== 8'h11) $display("FAIL aligned_lane0: got %h exp 11", bus.lane_data[0]); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd1) $display("FAIL aligned_sel1: got %0d exp 1", bus.sel); else pass_cnt++;
      beat(8'h22, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b0010) $display("FAIL aligned_lv1: got %b exp 0010", bus.lane_valid); else pass_cnt++;
      beat(8'h33, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b0100) $display("FAIL aligned_lv2: got %b exp 0100", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL aligned_fv_early: got %b exp 0", bus.frame_valid); else pass_cnt++;
      beat(8'h44, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b1000) $display("FAIL aligned_lv3: got %b exp 1000", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_valid !== 1'b1) $display("FAIL aligned_fv: got %b exp 1", bus.frame_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_data !== 32'h44332211) $display("FAIL aligned_frame: got %h exp 44332211", bus.frame_data); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd0) $display("FAIL aligned_sel_wrap: got %0d exp 0", bus.sel); else pass_cnt++;
      idle(1);
      total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL aligned_fv_pulse: got %b exp 0", bus.frame_valid); else pass_cnt++;
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL aligned_lv_pulse: got %b exp 0000", bus.lane_valid); else pass_cnt++;
   endtask

   task automatic test_unaligned();
      do_reset();
      beat(8'hAA, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL unal_lv_aa: got %b exp 0000", bus.lane_valid); else pass_cnt++;
      beat(8'hBB, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL unal_lv_bb: got %b exp 0000", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd0) $display("FAIL unal_sel: got %0d exp 0", bus.sel); else pass_cnt++;
      total_cnt++; if (bus.lane_data[0] !== 8'h00) $display("FAIL unal_lane0: got %h exp 00", bus.lane_data[0]); else pass_cnt++;
      beat(8'h01, 1'b1);
      total_cnt++; if (bus.lane_data[0] !== 8'h01) $display("FAIL unal_sof_lane0: got %h exp 01", bus.lane_data[0]); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd1) $display("FAIL unal_sof_sel: got %0d exp 1", bus.sel); else pass_cnt++;
      total_cnt++; if (dbg_state !== COLLECT) $display("FAIL unal_state: got %0d exp COLLECT", dbg_state); else pass_cnt++;
   endtask

   task automatic test_sof_no_valid();
      do_reset();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b1;
      bus.in_data  = 8'h5A;
      @(posedge clk);
      #1;
      bus.in_sof = 1'b0;
      total_cnt++; if (dbg_state !== HUNT) $display("FAIL sofnv_state: got %0d exp HUNT", dbg_state); else pass_cnt++;
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL sofnv_lv: got %b exp 0000", bus.lane_valid); else pass_cnt++;
   endtask

   task automatic test_gapped();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         beat(8'h10 + 8'(i), i == 0);
         total_cnt++; if (bus.lane_valid !== (4'b0001 << i)) $display("FAIL gap_lv%0d: got %b exp %b", i, bus.lane_valid, 4'b0001 << i); else pass_cnt++;
         idle(2);
         total_cnt++; if (bus.sel !== 2'((i + 1) % 4)) $display("FAIL gap_sel_hold%0d: got %0d exp %0d", i, bus.sel, (i + 1) % 4); else pass_cnt++;
      end
      total_cnt++; if (bus.frame_data !== 32'h13121110) $display("FAIL gap_frame: got %h exp 13121110", bus.frame_data); else pass_cnt++;
   endtask

   task automatic test_midframe_sync();
      beat(8'h01, 1'b1);
      beat(8'h02, 1'b0);
      total_cnt++; if (bus.sof_err !== 1'b0) $display("FAIL mid_no_err: got %b exp 0", bus.sof_err); else pass_cnt++;
      beat(8'h05, 1'b1);
      total_cnt++; if (bus.sof_err !== 1'b1) $display("FAIL mid_err: got %b exp 1", bus.sof_err); else pass_cnt++;
      total_cnt++; if (bus.lane_data[0] !== 8'h05) $display("FAIL mid_lane0: got %h exp 05", bus.lane_data[0]); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd1) $display("FAIL mid_sel: got %0d exp 1", bus.sel); else pass_cnt++;
      total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL mid_fv: got %b exp 0", bus.frame_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_data !== 32'h13121110) $display("FAIL mid_frame_hold: got %h exp 13121110", bus.frame_data); else pass_cnt++;
      beat(8'h06, 1'b0);
      total_cnt++; if (bus.sof_err !== 1'b0) $display("FAIL mid_err_pulse: got %b exp 0", bus.sof_err); else pass_cnt++;
      beat(8'h07, 1'b0);
      beat(8'h08, 1'b0);
      total_cnt++; if (bus.frame_valid !== 1'b1) $display("FAIL mid_resync_fv: got %b exp 1", bus.frame_valid); else pass_cnt++;
      total_cnt++; if (bus.frame_data !== 32'h08070605) $display("FAIL mid_resync_frame: got %h exp 08070605", bus.frame_data); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int fv_cnt;
      logic [31:0] exp_frame;
      fv_cnt = 0;
      do_reset();
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      for (int i = 1; i <= 8; i++) begin
         beat(8'(i), i == 1);
         total_cnt++; if (bus.lane_valid !== (4'b0001 << ((i - 1) % 4))) $display("FAIL b2b_lv%0d: got %b exp %b", i, bus.lane_valid, 4'b0001 << ((i - 1) % 4)); else pass_cnt++;
         if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            total_cnt++; if (bus.frame_data !== exp_frame) $display("FAIL b2b_frame%0d: got %h exp %h", i, bus.frame_data, exp_frame); else pass_cnt++;
         end
      end
      total_cnt++; if (fv_cnt !== 2) $display("FAIL b2b_fv_count: got %0d exp 2", fv_cnt); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d exp 0", exp_q.size()); else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_reset_midframe();
      do_reset();
      beat(8'h21, 1'b1);
      beat(8'h22, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.lane_data !== 32'h0) $display("FAIL rmid_lane_data: got %h exp 0", bus.lane_data); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd0) $display("FAIL rmid_sel: got %0d exp 0", bus.sel); else pass_cnt++;
      total_cnt++; if (dbg_state !== HUNT) $display("FAIL rmid_state: got %0d exp HUNT", dbg_state); else pass_cnt++;
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL rmid_lv: got %b exp 0000", bus.lane_valid); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat(8'h09, 1'b0);
      total_cnt++; if (bus.lane_valid !== 4'b0000) $display("FAIL rmid_drop_lv: got %b exp 0000", bus.lane_valid); else pass_cnt++;
      total_cnt++; if (bus.sel !== 2'd0) $display("FAIL rmid_drop_sel: got %0d exp 0", bus.sel); else pass_cnt++;
      total_cnt++; if (bus.lane_data[0] !== 8'h00) $display("FAIL rmid_drop_lane0: got %h exp 00", bus.lane_data[0]); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_aligned();
      test_unaligned();
      test_sof_no_valid();
      test_gapped();
      test_midframe_sync();
      test_back_to_back();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 8, is the bit width of each sample.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  a sample is present on in_data this cycle.
REQ-005 in_data  input  WIDTH  time-division-multiplexed sample.
REQ-006 in_sof  input  1  start of frame; qualified by in_valid; marks the lane-0 sample.
REQ-007 sel  output  2  lane index the next accepted sample is routed to.
REQ-008 lane_data  output  4 x WIDTH  last sample captured per lane; lane k holds the value for lane k.
REQ-009 lane_valid  output  4  one-cycle pulse, bit k, when lane k is updated.
REQ-010 frame_data  output  4 x WIDTH  coherent snapshot of one complete frame, lanes 0..3.
REQ-011 frame_valid  output  1  one-cycle pulse when frame_data is updated.
REQ-012 sof_err  output  1  one-cycle pulse when in_sof arrives mid-frame.
REQ-013 The block has one clock and one reset: clk and rst_n, asynchronous and active-low.

Function
REQ-014 The block SHALL implement two states: HUNT (unaligned) and COLLECT (aligned).
REQ-015 In HUNT, beats with in_valid=1 and in_sof=0 SHALL be dropped with no output change.
REQ-016 In HUNT, a beat with in_valid=1 and in_sof=1 SHALL be captured into lane 0, set sel to 1, and move to COLLECT.
REQ-017 In COLLECT, each beat with in_valid=1 SHALL be written to lane sel, and sel SHALL increment modulo 4.
REQ-018 In COLLECT, beats with in_valid=0 SHALL leave sel, lane_data and frame_data unchanged.
REQ-019 Latency: lane_data[k] and lane_valid[k] SHALL update on the clock edge that accepts the beat, so they are visible one cycle after the beat is presented.
REQ-020 After a frame is complete (sel wraps 3 to 0), the next beat SHALL be taken as lane 0 whether in_sof is 0 or 1.
REQ-021 When lane 3 is captured and all of lanes 0..2 belong to the same frame, frame_data SHALL load all four lanes and frame_valid SHALL pulse in the same cycle as lane_valid[3].
REQ-022 Mid-frame sync (in_valid=1, in_sof=1, sel!=0):
- sof_err SHALL pulse.
- The beat SHALL be captured into lane 0 and sel SHALL become 1.
- The partial frame SHALL be discarded: no frame_valid, and frame_data is unchanged.
REQ-023 in_sof with in_valid=0 SHALL be ignored.
REQ-024 At most one bit of lane_valid SHALL be set in any cycle.
REQ-025 frame_data SHALL never contain a mix of two frames.

Reset
REQ-026 While rst_n=0, all outputs and state SHALL clear immediately (asynchronously):
- state is HUNT and sel is 0.
- lane_data and frame_data are all 0.
- lane_valid, frame_valid and sof_err are 0.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame; after reset the block SHALL require in_sof to realign.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-029 Package tdm_pkg SHALL hold the constant LANES=4, the 2-bit lane index typedef, and the HUNT/COLLECT state enum.
REQ-030 The block SHALL be a single module with no sub-module; the lane pointer and the frame-complete flag are local registers.

Verification
REQ-031 Reset then aligned frame: rst_n low then high; beats 0x11 (sof), 0x22, 0x33, 0x44 on consecutive cycles -> lane_valid pulses 0001, 0010, 0100, 1000; frame_valid pulses once; frame_data = {0x11, 0x22, 0x33, 0x44}; sel returns to 0.
REQ-032 Unaligned input: beats 0xAA, 0xBB with in_sof=0 after reset -> no lane_valid and sel stays 0; then 0x01 with sof -> lane_data[0]=0x01, sel=1.
REQ-033 Gapped input: frame 0x10..0x13 with in_valid=0 idle cycles between beats -> same result as back-to-back; sel holds during the gaps.
REQ-034 Mid-frame sync: 0x01 (sof), 0x02, then 0x05 (sof) -> sof_err pulses once; lane_data[0]=0x05; sel=1; no frame_valid; frame_data unchanged.
REQ-035 Back-to-back frames without a second sof: 8 beats 0x01..0x08 after one sof -> two frame_valid pulses, giving frame_data {1,2,3,4} and then {5,6,7,8}.
REQ-036 Reset mid-frame: after 2 beats, rst_n pulsed low -> all outputs are 0 immediately; a following beat without sof is dropped.
